seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed controller for a common-bus multi-digit 7-segment display. It holds one BCD value per digit, scans the digits one at a time through a single shared digit decoder, and drives the one-hot digit enables and the segment bus. A blanking gap between digits prevents ghosting. New values enter through a load/ready handshake and are committed only at a frame boundary, so the display never shows a half-updated value.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- TICK_DIV, 50000: clock cycles per digit slot; must be greater than GAP_CYC.
- GAP_CYC, 2: cycles at the start of each slot with all digit enables low; must be at least 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to accept `value`; taken only when ready=1.
- value  in  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (least significant).
- blank_lz  in  1  level; 1 enables leading-zero blanking.
- ready  out  1  1 when no load is pending commit.
- dig_en  out  NUM_DIGITS  one-hot digit enable, active high; all zero during gaps.
- seg  out  7  segments {a,b,c,d,e,f,g}, active high.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Counters:
  - cnt runs 0..TICK_DIV-1 and wraps to 0.
  - idx (the digit index) advances by one on each cnt wrap and wraps NUM_DIGITS-1 → 0.
- Slot phases (derived from cnt, no separate state register):
  - GAP while cnt < GAP_CYC.
  - DRIVE while cnt ≥ GAP_CYC.
- Frame boundary: the edge at which cnt == TICK_DIV-1 and idx == NUM_DIGITS-1.
- Registers: disp (displayed digits), pending (captured value), pend_valid.
- Handshake:
  - load & ready on an edge: pending ← value, pend_valid ← 1, ready ← 0.
  - A load while ready=0 is ignored; the data is dropped and no error is flagged.
- Commit: at a frame boundary with pend_valid=1: disp ← pending, pend_valid ← 0, ready ← 1.
- Load on the frame-boundary edge while ready=1: the value is captured into pending. It is committed at the next boundary, not the current one.
- Per-digit decode of disp digit idx:
  - 0..9 map to the standard patterns:
    - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
    - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Codes 10..15 map to 0000000.
- Leading-zero blanking (blank_lz=1):
  - Digit i > 0 shows seg = 0000000 if digit i and all higher digits are 0.
  - Digit 0 is never blanked.
  - dig_en still asserts normally for blanked digits.
- Outputs during GAP: dig_en = 0 and seg = 0000000.

## Timing
- Reset values:
  - cnt=0, idx=0, disp=0, pending=0, pend_valid=0.
  - ready=1, dig_en=0, seg=0000000, frame_done=0.
- Reset assertion clears all registers immediately, without waiting for a clock; this includes mid-frame, where any pending load is discarded.
- dig_en and seg are registered: after edge k they reflect the cnt/idx state held before edge k, i.e. one cycle of latency.
- After reset release:
  - dig_en[0] first goes high after edge GAP_CYC+1.
  - Each digit is enabled for TICK_DIV-GAP_CYC cycles per slot.
- Frame period = NUM_DIGITS*TICK_DIV cycles.
- frame_done is high for exactly the cycle following the frame-boundary edge.
- ready:
  - Falls the cycle after the accepting edge.
  - Rises the cycle after the committing edge, coincident with frame_done.
- Newly committed digits appear starting with digit 0's first DRIVE output of the next frame.

## Structure
- Package seg7_pkg holds:
  - constants SEG_0..SEG_9 and SEG_BLANK;
  - the segment bit-order definition.
- Sub-module seg7_digit_dec: purely combinational 4-bit BCD → 7-bit pattern decoder using the package constants. It is instantiated once and fed through a mux on idx.
- Top level contains the counters, handshake registers, leading-zero logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=8, GAP_CYC=2.
- Reset then free-run:
  - dig_en = 0000 through edge 2, then 0001 for 6 cycles, then 0000 for 2 cycles, then 0010.
  - seg = 1111110 while driving.
  - frame_done pulses every 32 cycles.
- Load value=0x1234 with ready=1:
  - ready = 0 the next cycle, and digits keep showing 0 until frame_done.
  - In the next frame, digit0 seg=0110011 (4), digit1 1111001 (3), digit2 1101101 (2), digit3 0110000 (1).
  - ready = 1 with frame_done.
- Leading-zero blanking, blank_lz=1:
  - value 0x0050: digits 3 and 2 show 0000000, digit1 shows 1011011, digit0 shows 1111110.
  - value 0x0000: only digit0 shows 1111110.
- Invalid BCD: value 0x00A0 → digit1 seg=0000000, other digits show 0.
- Handshake edges:
  - Load 0x1111 on the frame-boundary edge: committed one frame later, not immediately.
  - A second load of 0x9999 while ready=0 is dropped; 0x1111 is displayed.
- Asynchronous reset mid-slot with a load pending:
  - dig_en, seg and frame_done go to 0 and ready to 1 before the next clock edge.
  - After release the display shows 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment encodings and slot-phase type for the multiplexed 7-segment controller.
package seg7_pkg;

  // Segment bus order, MSB first: {a,b,c,d,e,f,g}.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    PH_GAP,
    PH_DRIVE
  } phase_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load/ready handshake carrying a new set of BCD digits into the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    ready;

  modport master (output load, output value, input ready);
  modport slave  (input load, input value, output ready);
endinterface

// File: rtl/seg7_digit_dec.sv
// Combinational BCD to 7-segment decoder; non-decimal codes produce a dark digit.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed multi-digit 7-segment scanner with blanking gaps, leading-zero
// suppression and frame-aligned commit of newly loaded digit values.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_ctrl_if.slave       bus,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic                  cnt_wrap, idx_last, boundary;
  phase_e                phase;
  logic [3:0]            digit_sel;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run, blank_sel;

  seg7_digit_dec u_dec (
    .bcd (digit_sel),
    .seg (dec_seg)
  );

  always_comb begin
    cnt_wrap = (cnt_q == CNT_W'(TICK_DIV - 1));
    idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = cnt_wrap && idx_last;
    phase    = (cnt_q < CNT_W'(GAP_CYC)) ? PH_GAP : PH_DRIVE;

    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);

    // Accept and commit are exclusive: accepting needs pend_valid=0, committing needs 1,
    // so a load on the boundary edge waits for the following boundary.
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (bus.load && !pend_valid_q) begin
      pend_d       = bus.value;
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end

    frame_done_d = boundary;
  end

  // Digit i>0 is blanked when it and every higher digit are zero; scan from the top down.
  always_comb begin
    zero_run  = 1'b1;
    lz_blank  = '0;
    digit_sel = '0;
    blank_sel = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run & (disp_q[(NUM_DIGITS-1-k)*4 +: 4] == 4'd0);
      lz_blank[NUM_DIGITS-1-k] = zero_run & (k + 1 < NUM_DIGITS);
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_sel = disp_q[i*4 +: 4];
        blank_sel = blank_lz & lz_blank[i];
      end
    end
  end

  always_comb begin
    dig_en_d = '0;
    seg_d    = SEG_BLANK;
    if (phase == PH_DRIVE) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        dig_en_d[i] = (idx_q == IDX_W'(i));
      end
      seg_d = blank_sel ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      dig_en_q     <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      dig_en_q     <= dig_en_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ready  = ~pend_valid_q;
  assign dig_en     = dig_en_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed-vector bench for seg7_scan_ctrl with NUM_DIGITS=4, TICK_DIV=8, GAP_CYC=2.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 8;
  localparam int GC = 2;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] BL = 7'b0000000;

  logic          clk;
  logic          rst;
  logic          blank_lz;
  logic [ND-1:0] dig_en;
  logic [6:0]    seg;
  logic          frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_if ();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .GAP_CYC(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .blank_lz   (blank_lz),
    .dig_en     (dig_en),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame_done === 1'b1) found = 1'b1;
    end
    total_cnt++;
    if (!found) $display("FAIL frame_wait: frame_done=0 for 40 cycles, expected a pulse");
    else pass_cnt++;
  endtask

  // Runs one full frame from a frame_done cycle to the next, recording each digit's segments.
  task automatic capture_frame(input logic do_load, input logic [15:0] ld_val,
                               output logic [27:0] segs, output logic [3:0] seen);
    segs = '0;
    seen = '0;
    if (do_load) begin
      bus_if.load  = 1'b1;
      bus_if.value = ld_val;
    end
    for (int c = 0; c < ND*TD; c++) begin
      tick();
      bus_if.load = 1'b0;
      for (int i = 0; i < ND; i++) begin
        if (dig_en === (4'b0001 << i)) begin
          segs[i*7 +: 7] = seg;
          seen[i]        = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_fd;
    rst = 1'b1;
    repeat (2) tick();
    total_cnt += 4;
    if (dig_en !== 4'b0000) $display("FAIL rst_dig_en: got %b expected 0000", dig_en); else pass_cnt++;
    if (seg !== BL) $display("FAIL rst_seg: got %b expected 0000000", seg); else pass_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else pass_cnt++;
    if (bus_if.ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bus_if.ready); else pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k <= 11) begin
        exp_en  = (k <= 2) ? 4'b0000 : (k <= 8) ? 4'b0001 : (k <= 10) ? 4'b0000 : 4'b0010;
        exp_seg = (exp_en != 4'b0000) ? S0 : BL;
        total_cnt += 2;
        if (dig_en !== exp_en) $display("FAIL run_dig_en edge%0d: got %b expected %b", k, dig_en, exp_en);
        else pass_cnt++;
        if (seg !== exp_seg) $display("FAIL run_seg edge%0d: got %b expected %b", k, seg, exp_seg);
        else pass_cnt++;
      end
      exp_fd = (k == 32) || (k == 64);
      total_cnt++;
      if (frame_done !== exp_fd) $display("FAIL run_frame_done edge%0d: got %b expected %b", k, frame_done, exp_fd);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    logic [27:0] segs, exp;
    logic [3:0]  seen;
    bit          found = 1'b0;
    repeat (3) tick();
    bus_if.load  = 1'b1;
    bus_if.value = 16'h1234;
    tick();
    bus_if.load = 1'b0;
    total_cnt++;
    if (bus_if.ready !== 1'b0) $display("FAIL load_ready_fall: got %b expected 0", bus_if.ready); else pass_cnt++;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame_done === 1'b1) found = 1'b1;
      else if (dig_en !== 4'b0000) begin
        total_cnt++;
        if (seg !== S0) $display("FAIL load_old_value: got %b expected %b", seg, S0); else pass_cnt++;
      end
    end
    total_cnt += 2;
    if (!found) $display("FAIL load_frame_done: got 0 for 40 cycles expected 1"); else pass_cnt++;
    if (bus_if.ready !== 1'b1) $display("FAIL load_ready_rise: got %b expected 1", bus_if.ready); else pass_cnt++;
    capture_frame(1'b0, 16'h0, segs, seen);
    exp = {S1, S2, S3, S4};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL load_1234 digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL frame_period: got frame_done=%b expected 1", frame_done); else pass_cnt++;
  endtask

  task automatic test_lz();
    logic [27:0] segs, exp;
    logic [3:0]  seen;
    blank_lz = 1'b1;
    capture_frame(1'b1, 16'h0050, segs, seen);
    capture_frame(1'b0, 16'h0, segs, seen);
    exp = {BL, BL, S5, S0};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL lz_0050 digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
    total_cnt++;
    if (seen !== 4'b1111) $display("FAIL lz_dig_en: got %b expected 1111", seen); else pass_cnt++;
    capture_frame(1'b1, 16'h0000, segs, seen);
    capture_frame(1'b0, 16'h0, segs, seen);
    exp = {BL, BL, BL, S0};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL lz_0000 digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_invalid_bcd();
    logic [27:0] segs, exp;
    logic [3:0]  seen;
    capture_frame(1'b1, 16'h00A0, segs, seen);
    capture_frame(1'b0, 16'h0, segs, seen);
    exp = {S0, S0, BL, S0};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL invalid_00A0 digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] segs, exp;
    logic [3:0]  seen;
    repeat (ND*TD - 1) tick();
    bus_if.load  = 1'b1;
    bus_if.value = 16'h1111;
    tick();
    bus_if.load = 1'b0;
    total_cnt += 2;
    if (frame_done !== 1'b1) $display("FAIL b2b_boundary: got frame_done=%b expected 1", frame_done); else pass_cnt++;
    if (bus_if.ready !== 1'b0) $display("FAIL b2b_ready: got %b expected 0", bus_if.ready); else pass_cnt++;
    capture_frame(1'b1, 16'h9999, segs, seen);
    exp = {S0, S0, BL, S0};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL b2b_not_early digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus_if.ready !== 1'b1) $display("FAIL b2b_commit_ready: got %b expected 1", bus_if.ready); else pass_cnt++;
    capture_frame(1'b0, 16'h0, segs, seen);
    exp = {S1, S1, S1, S1};
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== exp[i*7 +: 7])
        $display("FAIL b2b_1111 digit%0d: got %b expected %b", i, segs[i*7 +: 7], exp[i*7 +: 7]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [27:0] segs;
    logic [3:0]  seen;
    bus_if.load  = 1'b1;
    bus_if.value = 16'h5678;
    tick();
    bus_if.load = 1'b0;
    repeat (4) tick();
    total_cnt += 2;
    if (bus_if.ready !== 1'b0) $display("FAIL areset_pre_ready: got %b expected 0", bus_if.ready); else pass_cnt++;
    if (dig_en !== 4'b0001) $display("FAIL areset_pre_dig_en: got %b expected 0001", dig_en); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt += 4;
    if (dig_en !== 4'b0000) $display("FAIL areset_dig_en: got %b expected 0000", dig_en); else pass_cnt++;
    if (seg !== BL) $display("FAIL areset_seg: got %b expected 0000000", seg); else pass_cnt++;
    if (frame_done !== 1'b0) $display("FAIL areset_frame_done: got %b expected 0", frame_done); else pass_cnt++;
    if (bus_if.ready !== 1'b1) $display("FAIL areset_ready: got %b expected 1", bus_if.ready); else pass_cnt++;
    #1 rst = 1'b0;
    wait_frame_done();
    capture_frame(1'b0, 16'h0, segs, seen);
    for (int i = 0; i < ND; i++) begin
      total_cnt++;
      if (segs[i*7 +: 7] !== S0)
        $display("FAIL areset_display digit%0d: got %b expected %b", i, segs[i*7 +: 7], S0);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    blank_lz     = 1'b0;
    bus_if.load  = 1'b0;
    bus_if.value = '0;
    test_reset();
    test_load();
    test_lz();
    test_invalid_bcd();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, expected completion");
    $fatal(1);
  end

endmodule
